// File: rtl/core_mem_port.sv
// core_mem_port: turns single-cycle core load/store requests into one Avalon-MM
// master transaction each. It returns a one-cycle mem_ready completion pulse.
// User-mode accesses above USER_LIMIT fault without touching the bus. A request
// stuck in REQ or WAIT_RD for TIMEOUT cycles is completed with mem_fault.
module core_mem_port #(
  parameter logic [29:0] USER_LIMIT = 30'h2000_0000,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // core request side
  input  logic [29:0] mem_addr,
  input  logic        mem_start,
  input  logic        mem_write,
  input  logic        mem_user,
  input  logic [3:0]  mem_data_be,
  input  logic [31:0] mem_data_wr,
  output logic        mem_ready,
  output logic [31:0] mem_data_rd,
  output logic        mem_fault,
  output logic        busy,
  // Avalon-MM master side
  output logic [31:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [3:0]  avl_byteenable,
  output logic [31:0] avl_writedata,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid
);

  // The counter only has to reach TIMEOUT-1. Keep it at least one bit wide so a
  // disabled timeout (TIMEOUT=0) still elaborates.
  localparam int unsigned CntW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned CntLast  = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CntW-1:0] CntLastW = CntW'(CntLast);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWaitRd,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [29:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            read_q, read_d;
  logic            write_q, write_d;
  logic            fault_q, fault_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;

  logic priv_fault;
  logic timeout_hit;

  // Unsigned word-address compare; only unprivileged requests are limited.
  assign priv_fault = mem_user && (mem_addr >= USER_LIMIT);

  // The cycle with cnt_q == TIMEOUT-1 is the last one spent in REQ/WAIT_RD.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntLastW);

  // State and datapath registers; reset drops the bus strobes asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and datapath update for the request sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    unique case (state_q)
      StIdle: begin
        // Late readdatavalid after a timeout lands here and is ignored.
        if (mem_start) begin
          addr_d  = mem_addr;
          be_d    = mem_data_be;
          wdata_d = mem_data_wr;
          cnt_d   = '0;
          if (priv_fault) begin
            fault_d = 1'b1;
            state_d = StDone;
          end else begin
            fault_d = 1'b0;
            read_d  = !mem_write;
            write_d = mem_write;
            state_d = StReq;
          end
        end
      end

      StReq: begin
        cnt_d = cnt_q + CntOne;
        if (!avl_waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (write_q) begin
            fault_d = 1'b0;
            state_d = StDone;
          end else if (avl_readdatavalid) begin
            // Zero-latency slave: data arrives together with acceptance.
            rdata_d = avl_readdata;
            fault_d = 1'b0;
            state_d = StDone;
          end else if (timeout_hit) begin
            fault_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWaitRd;
          end
        end else if (timeout_hit) begin
          // Abandon a request the slave never accepted.
          read_d  = 1'b0;
          write_d = 1'b0;
          fault_d = 1'b1;
          state_d = StDone;
        end
      end

      StWaitRd: begin
        cnt_d = cnt_q + CntOne;
        // Data arriving on the final allowed cycle still counts as success.
        if (avl_readdatavalid) begin
          rdata_d = avl_readdata;
          fault_d = 1'b0;
          state_d = StDone;
        end else if (timeout_hit) begin
          fault_d = 1'b1;
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign mem_ready      = (state_q == StDone);
  assign mem_fault      = mem_ready & fault_q;
  assign busy           = (state_q != StIdle);
  assign mem_data_rd    = rdata_q;
  assign avl_address    = {addr_q, 2'b00};
  assign avl_read       = read_q;
  assign avl_write      = write_q;
  assign avl_byteenable = be_q;
  assign avl_writedata  = wdata_q;

  // Read and write strobes are never asserted together.
  a_rw_excl: assert property (@(posedge clk) disable iff (!rst_n) !(avl_read && avl_write));

  // Completion is a single-cycle pulse.
  a_ready_pulse: assert property (@(posedge clk) disable iff (!rst_n) mem_ready |=> !mem_ready);

  // A fault is only ever reported alongside a completion.
  a_fault_ready: assert property (@(posedge clk) disable iff (!rst_n) mem_fault |-> mem_ready);

  // A stalled request keeps its address, enables, data and strobe unchanged.
  a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (avl_read || avl_write) && avl_waitrequest && !timeout_hit |=>
      $stable(avl_address) && $stable(avl_byteenable) && $stable(avl_writedata) &&
      $stable(avl_read) && $stable(avl_write));

endmodule

// File: tb/tb_core_mem_port.sv
// tb_core_mem_port: scoreboard bench for core_mem_port with a small Avalon slave.
module tb_core_mem_port;

  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] mem_addr = '0;
  logic        mem_start = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_user = 1'b0;
  logic [3:0]  mem_data_be = '0;
  logic [31:0] mem_data_wr = '0;
  logic        mem_ready;
  logic [31:0] mem_data_rd;
  logic        mem_fault;
  logic        busy;
  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [3:0]  avl_byteenable;
  logic [31:0] avl_writedata;
  logic        avl_waitrequest = 1'b0;
  logic [31:0] avl_readdata = '0;
  logic        avl_readdatavalid = 1'b0;

  core_mem_port #(
    .USER_LIMIT(30'h2000_0000),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_addr         (mem_addr),
    .mem_start        (mem_start),
    .mem_write        (mem_write),
    .mem_user         (mem_user),
    .mem_data_be      (mem_data_be),
    .mem_data_wr      (mem_data_wr),
    .mem_ready        (mem_ready),
    .mem_data_rd      (mem_data_rd),
    .mem_fault        (mem_fault),
    .busy             (busy),
    .avl_address      (avl_address),
    .avl_read         (avl_read),
    .avl_write        (avl_write),
    .avl_byteenable   (avl_byteenable),
    .avl_writedata    (avl_writedata),
    .avl_waitrequest  (avl_waitrequest),
    .avl_readdata     (avl_readdata),
    .avl_readdatavalid(avl_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
    int unsigned start;
    int unsigned lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;

  // slave configuration and state
  int          cfg_wait = 0;
  int          cfg_lat = 1;
  bit          cfg_no_valid = 1'b0;
  logic [31:0] cfg_rdata = '0;
  bit          inject_valid = 1'b0;
  int          stall_left = 0;
  bit          rd_pending = 1'b0;
  int          rd_delay = 0;

  // monitor state
  int          n_accept = 0;
  int          n_ready = 0;
  int          n_rd_hi = 0;
  int          n_wr_hi = 0;
  int          strobe_run = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_rd = 1'b0;
  logic [31:0] model_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Negedge sampling: bus stability and scoreboard pop on mem_ready.
  task automatic monitor();
    exp_t e;
    if (!rst_n) begin
      strobe_run = 0;
      return;
    end
    if (avl_read || avl_write) begin
      if (avl_read) n_rd_hi++;
      if (avl_write) n_wr_hi++;
      if (strobe_run == 0) begin
        cap_addr  = avl_address;
        cap_wdata = avl_writedata;
        cap_be    = avl_byteenable;
        cap_rd    = avl_read;
      end else begin
        check("hold_addr", avl_address, cap_addr);
        check("hold_be", 32'(avl_byteenable), 32'(cap_be));
        check("hold_wdata", avl_writedata, cap_wdata);
        check("hold_rd", 32'(avl_read), 32'(cap_rd));
      end
      strobe_run++;
    end else begin
      strobe_run = 0;
    end
    if (mem_ready) begin
      n_ready++;
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(mem_ready), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_fault", 32'(mem_fault), 32'(e.fault));
        check("sb_rdata", mem_data_rd, e.rdata);
        check("sb_latency", 32'(cyc - e.start), 32'(e.lat));
      end
    end else if (mem_fault) begin
      check("fault_without_ready", 32'(mem_fault), 32'd0);
    end
  endtask

  // Avalon slave: cfg_wait stall cycles, then readdatavalid cfg_lat cycles later.
  task automatic slave();
    avl_readdatavalid = 1'b0;
    if (!rst_n) begin
      rd_pending      = 1'b0;
      avl_waitrequest = 1'b0;
      stall_left      = cfg_wait;
      return;
    end
    if (inject_valid) begin
      avl_readdatavalid = 1'b1;
      avl_readdata      = cfg_rdata;
      inject_valid      = 1'b0;
    end
    if (rd_pending) begin
      if (rd_delay == 0) begin
        avl_readdatavalid = 1'b1;
        avl_readdata      = cfg_rdata;
        rd_pending        = 1'b0;
      end else begin
        rd_delay--;
      end
    end
    if (avl_read || avl_write) begin
      if (stall_left > 0) begin
        avl_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avl_waitrequest = 1'b0;
        n_accept++;
        stall_left = cfg_wait;
        if (avl_read && !cfg_no_valid) begin
          if (cfg_lat == 0) begin
            avl_readdatavalid = 1'b1;
            avl_readdata      = cfg_rdata;
          end else begin
            rd_pending = 1'b1;
            rd_delay   = cfg_lat - 1;
          end
        end
      end
    end else begin
      avl_waitrequest = 1'b0;
      stall_left      = cfg_wait;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    slave();
  endtask

  // Drive one mem_start pulse and push the expected completion.
  task automatic issue(input logic [29:0] addr, input logic wr, input logic user,
                       input logic [3:0] be, input logic [31:0] wdata, input int wt,
                       input int lat, input bit novalid, input logic [31:0] rdata,
                       input logic exp_fault, input int unsigned exp_lat);
    exp_t e;
    cfg_wait     = wt;
    stall_left   = wt;
    cfg_lat      = lat;
    cfg_no_valid = novalid;
    cfg_rdata    = rdata;
    mem_addr     = addr;
    mem_write    = wr;
    mem_user     = user;
    mem_data_be  = be;
    mem_data_wr  = wdata;
    mem_start    = 1'b1;
    if (!exp_fault && !wr) model_rd = rdata;
    e.fault = exp_fault;
    e.rdata = model_rd;
    e.start = cyc;
    e.lat   = exp_lat;
    exp_q.push_back(e);
    tick();
    mem_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    int i;
    base = n_ready;
    i = 0;
    while (n_ready == base && i < budget) begin
      tick();
      i++;
    end
    check(tag, 32'(n_ready - base), 32'd1);
    check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int rd0, wr0, acc0, rdy0;

    // reset state
    repeat (3) tick();
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_fault", 32'(mem_fault), 32'd0);
    check("rst_rdata", mem_data_rd, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_read", 32'(avl_read), 32'd0);
    check("rst_write", 32'(avl_write), 32'd0);
    check("rst_addr", avl_address, 32'd0);
    check("rst_be", 32'(avl_byteenable), 32'd0);
    check("rst_wdata", avl_writedata, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // read, zero wait states, data one cycle after accept
    rd0 = n_rd_hi;
    issue(30'h0000_0100, 1'b0, 1'b0, 4'hF, 32'h0, 0, 1, 1'b0, 32'hDEAD_BEEF, 1'b0, 3);
    wait_done("t1_done", 20);
    check("t1_rd_cycles", 32'(n_rd_hi - rd0), 32'd1);
    check("t1_addr", cap_addr, 32'h0000_0400);

    // write with three waitrequest cycles
    wr0 = n_wr_hi;
    issue(30'h0000_0040, 1'b1, 1'b0, 4'b0011, 32'h1234_5678, 3, 1, 1'b0, 32'h0, 1'b0, 5);
    wait_done("t2_done", 20);
    check("t2_wr_cycles", 32'(n_wr_hi - wr0), 32'd4);
    check("t2_addr", cap_addr, 32'h0000_0100);
    check("t2_be", 32'(cap_be), 32'h3);
    check("t2_wdata", cap_wdata, 32'h1234_5678);

    // user fault at the limit, then just below it
    rd0 = n_rd_hi;
    wr0 = n_wr_hi;
    issue(30'h2000_0000, 1'b0, 1'b1, 4'hF, 32'h0, 0, 0, 1'b0, 32'h1111_1111, 1'b1, 1);
    wait_done("t3_fault_done", 10);
    check("t3_no_strobe", 32'((n_rd_hi - rd0) + (n_wr_hi - wr0)), 32'd0);
    issue(30'h1FFF_FFFF, 1'b0, 1'b1, 4'hF, 32'h0, 0, 0, 1'b0, 32'hA5A5_0001, 1'b0, 2);
    wait_done("t3_ok_done", 10);
    check("t3_rd_cycles", 32'(n_rd_hi - rd0), 32'd1);
    check("t3_addr", cap_addr, 32'h7FFF_FFFC);

    // timeout: read accepted but no readdatavalid
    issue(30'h0000_0200, 1'b0, 1'b0, 4'hF, 32'h0, 0, 1, 1'b1, 32'h0, 1'b1, TIMEOUT + 1);
    wait_done("t4_done", 30);
    rdy0 = n_ready;
    cfg_rdata    = 32'hCAFE_F00D;
    inject_valid = 1'b1;
    repeat (3) tick();
    check("t4_late_rdata", mem_data_rd, model_rd);
    check("t4_late_no_ready", 32'(n_ready - rdy0), 32'd0);
    check("t4_late_busy", 32'(busy), 32'd0);

    // back-to-back: start issued in the cycle right after mem_ready
    acc0 = n_accept;
    issue(30'h0000_0010, 1'b1, 1'b0, 4'hF, 32'h0F0F_0F0F, 0, 0, 1'b0, 32'h0, 1'b0, 2);
    wait_done("t5_first", 10);
    issue(30'h0000_0011, 1'b0, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0BAD_CAFE, 1'b0, 2);
    wait_done("t5_second", 10);
    check("t5_accepts", 32'(n_accept - acc0), 32'd2);

    // stray mem_start during REQ is ignored
    acc0 = n_accept;
    rdy0 = n_ready;
    wr0  = n_wr_hi;
    issue(30'h0000_0020, 1'b1, 1'b0, 4'b1100, 32'h5555_AAAA, 3, 0, 1'b0, 32'h0, 1'b0, 5);
    mem_addr    = 30'h0000_03FF;
    mem_write   = 1'b0;
    mem_data_wr = 32'hFFFF_FFFF;
    mem_start   = 1'b1;
    tick();
    mem_start = 1'b0;
    wait_done("t5_stray_done", 20);
    repeat (4) tick();
    check("t5_stray_accepts", 32'(n_accept - acc0), 32'd1);
    check("t5_stray_readies", 32'(n_ready - rdy0), 32'd1);
    check("t5_stray_wr_cycles", 32'(n_wr_hi - wr0), 32'd4);
    check("t5_stray_addr", cap_addr, 32'h0000_0080);

    // asynchronous reset while stalled in REQ
    cfg_wait    = 20;
    stall_left  = 20;
    mem_addr    = 30'h0000_0300;
    mem_write   = 1'b0;
    mem_user    = 1'b0;
    mem_start   = 1'b1;
    tick();
    mem_start = 1'b0;
    tick();
    check("t6_pre_read", 32'(avl_read), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_read", 32'(avl_read), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_ready", 32'(mem_ready), 32'd0);
    check("t6_rst_rdata", mem_data_rd, 32'd0);
    check("t6_rst_addr", avl_address, 32'd0);
    model_rd = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check("t6_no_ready", 32'(exp_q.size()), 32'd0);
    issue(30'h0000_0055, 1'b0, 1'b0, 4'hF, 32'h0, 0, 1, 1'b0, 32'h1357_9BDF, 1'b0, 3);
    wait_done("t6_after_done", 20);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_mem_port.md
Name: core_mem_port

Overview:
- Memory-side responder for the core's load/store request interface (mem_start/mem_addr/mem_write/mem_data_be/mem_data_wr/mem_user → mem_ready/mem_data_rd).
- Converts each one-cycle mem_start request into a single Avalon-MM master transaction toward the system interconnect, then returns a one-cycle mem_ready completion pulse.
- Also enforces a user-mode address limit and a bus timeout, reporting either condition as mem_fault.

Parameters:
- USER_LIMIT, 30'h2000_0000: word-address bound; user accesses with mem_addr >= USER_LIMIT fault without a bus cycle.
- TIMEOUT, 255: maximum cycles spent in REQ or WAIT_RD before forced fault completion; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  30  word address (byte address [31:2])
- mem_start  in  1  one-cycle request strobe
- mem_write  in  1  1=store, 0=load
- mem_user  in  1  unprivileged access
- mem_data_be  in  4  byte enables
- mem_data_wr  in  32  store data
- mem_ready  out  1  one-cycle completion pulse
- mem_data_rd  out  32  load data, valid with mem_ready, held until next load completes
- mem_fault  out  1  valid with mem_ready: privilege or timeout fault
- busy  out  1  high in any state other than IDLE
- avl_address  out  32  byte address {mem_addr,2'b00}
- avl_read  out  1  Avalon read
- avl_write  out  1  Avalon write
- avl_byteenable  out  4  Avalon byte enables
- avl_writedata  out  32  Avalon write data
- avl_waitrequest  in  1  Avalon stall
- avl_readdata  in  32  Avalon read data
- avl_readdatavalid  in  1  Avalon read data strobe

Behaviour:
- Reset values: mem_ready=0, mem_fault=0, mem_data_rd=0, busy=0, avl_read=0, avl_write=0, avl_address=0, avl_byteenable=0, avl_writedata=0. State=IDLE, timeout counter=0.
- Reset is asynchronous: asserting rst_n mid-transaction drops avl_read/avl_write immediately. No completion pulse is produced for the aborted request.
- States: IDLE, REQ, WAIT_RD, DONE.
- IDLE:
  - On mem_start, latch addr, write, be, wdata, user.
  - If mem_user && mem_addr >= USER_LIMIT (unsigned compare): go to DONE with fault=1; no avl_read/avl_write is ever asserted.
  - Otherwise go to REQ. avl_read=!mem_write or avl_write=mem_write is registered, first visible the cycle after mem_start.
- REQ:
  - Hold address, byteenable, writedata and the read/write strobe constant while avl_waitrequest=1.
  - On a cycle with avl_waitrequest=0, deassert the strobe. A write goes to DONE with fault=0; a read goes to WAIT_RD.
  - If avl_readdatavalid is already high in the accept cycle, capture the data and go directly to DONE.
- WAIT_RD:
  - On avl_readdatavalid, register mem_data_rd<=avl_readdata and go to DONE with fault=0.
- DONE: mem_ready=1 and mem_fault=fault for exactly one cycle, then IDLE. The next mem_start is accepted in the following cycle.
- Minimum latency, mem_start to mem_ready:
  - Privilege fault: 1 cycle.
  - Write with no wait states: 2 cycles.
  - Read with readdatavalid in the accept cycle: 2 cycles.
- Timeout (TIMEOUT>0):
  - The counter clears on leaving IDLE and increments each cycle in REQ or WAIT_RD.
  - When it reaches TIMEOUT: drop any strobe, go to DONE with fault=1, and leave mem_data_rd unchanged.
  - After a timeout, a late avl_readdatavalid arriving in IDLE/DONE is ignored.
- mem_start while busy=1: ignored; latched request unchanged. The issuing side only starts on or after mem_ready.
- mem_data_rd is updated only on a successful read; writes and faults leave it unchanged.

Test Plan:
- Read, zero wait states: start at addr 30'h0000_0100, waitrequest=0, readdatavalid+readdata=32'hDEADBEEF one cycle after accept.
  → avl_address=32'h0000_0400 and avl_read high for 1 cycle, then mem_ready with mem_data_rd=32'hDEADBEEF and mem_fault=0.
- Write with 3 waitrequest cycles: be=4'b0011, wdata=32'h1234_5678.
  → avl_write held 4 cycles with stable address, byteenable and data; mem_ready 1 cycle after acceptance, fault=0; mem_data_rd unchanged.
- User fault: mem_user=1, addr=30'h2000_0000.
  → no avl strobe ever; mem_ready and mem_fault both high 1 cycle after start. Repeat with addr=30'h1FFF_FFFF → normal bus cycle.
- Timeout: TIMEOUT=8, read accepted, no readdatavalid.
  → mem_ready+mem_fault 8 cycles after REQ entry; a later readdatavalid is ignored and mem_data_rd keeps its old value.
- Back-to-back: second mem_start in the cycle after mem_ready → accepted. A mem_start pulsed during REQ → ignored; exactly one avl transaction and one mem_ready.
- Reset mid-REQ with waitrequest=1: rst_n low → avl_read=0 asynchronously and all outputs at reset values; after release, a new read completes normally.
